// File: rtl/glide_slewer.sv
// glide_slewer: slews a DDS tuning word toward a requested target.
// Each tick_en moves phase_inc_o one step toward the target, clamped so it
// never overshoots, wraps or underflows. done_o pulses once when the target
// is reached.
// Optional exponential glide is enabled by defining GLIDE_EXP_EN. In that
// build, with exp_mode_i = 1, the step is max(|target - phase| >> step_i[4:0], 1).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | phase_inc_o equals the target (or no target loaded); holding
// UP    | phase_inc_o below target; adds step on each tick
// DOWN  | phase_inc_o above target; subtracts step on each tick
module glide_slewer #(
  parameter int WORD_BITS = 32,
  parameter int RATE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tick_en,
  input  logic [WORD_BITS-1:0] target_i,
  input  logic                 target_valid,
  input  logic [RATE_BITS-1:0] step_i,
  input  logic                 exp_mode_i,
  output logic [WORD_BITS-1:0] phase_inc_o,
  output logic                 gliding_o,
  output logic                 done_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WORD_BITS-1:0] phase_q, phase_d;
  logic [WORD_BITS-1:0] target_q, target_d;
  logic                 done_q, done_d;

  logic [WORD_BITS-1:0] step_w;
  logic                 lin_zero;
  logic [WORD_BITS:0]   sum_w;
  logic [WORD_BITS:0]   diff_w;

`ifdef GLIDE_EXP_EN
  logic [WORD_BITS-1:0] delta_w;
  logic [WORD_BITS-1:0] shifted_w;

  // Step size: exponential (distance-proportional, floor 1) or linear
  always_comb begin
    delta_w   = (state_q == DOWN) ? (phase_q - target_q) : (target_q - phase_q);
    shifted_w = delta_w >> step_i[4:0];
    if (exp_mode_i) begin
      step_w   = (shifted_w == '0) ? WORD_BITS'(1) : shifted_w;
      lin_zero = 1'b0;
    end else begin
      step_w   = WORD_BITS'(step_i);
      lin_zero = (step_i == '0);
    end
  end
`else
  logic unused_exp_mode;
  assign unused_exp_mode = exp_mode_i;

  // Step size: linear only, step_i zero-extended to the word width
  always_comb begin
    step_w   = WORD_BITS'(step_i);
    lin_zero = (step_i == '0);
  end
`endif

  // One extra bit catches carry out of the add and borrow out of the subtract
  assign sum_w  = {1'b0, phase_q} + {1'b0, step_w};
  assign diff_w = {1'b0, phase_q} - {1'b0, step_w};

  // Next-state logic: target load takes priority over stepping
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    target_d = target_q;
    done_d   = 1'b0;
    if (target_valid) begin
      target_d = target_i;
      if (target_i == phase_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (lin_zero) begin
        // A zero linear rate means "jump now" rather than "never arrive"
        phase_d = target_i;
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (target_i > phase_q) begin
        state_d = UP;
      end else begin
        state_d = DOWN;
      end
    end else if (tick_en) begin
      case (state_q)
        UP: begin
          if (sum_w >= {1'b0, target_q}) begin
            phase_d = target_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            phase_d = sum_w[WORD_BITS-1:0];
          end
        end
        DOWN: begin
          if (diff_w[WORD_BITS] || (diff_w[WORD_BITS-1:0] <= target_q)) begin
            phase_d = target_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            phase_d = diff_w[WORD_BITS-1:0];
          end
        end
        IDLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, tuning word, target and done registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  assign phase_inc_o = phase_q;
  assign gliding_o   = (state_q == UP) || (state_q == DOWN);
  assign done_o      = done_q;

endmodule

// File: tb/tb_glide_slewer.sv
// Directed bench for glide_slewer: per-cycle vector table plus hand sequences
// for the ramp, clamp, no-wrap, retarget, async-reset and exponential cases.
module tb_glide_slewer;

  logic        clk;
  logic        n_rst;
  logic        tick_en;
  logic [31:0] target_i;
  logic        target_valid;
  logic [15:0] step_i;
  logic        exp_mode_i;
  logic [31:0] phase_inc_o;
  logic        gliding_o;
  logic        done_o;

  int n_cmp = 0;
  int n_err = 0;

  glide_slewer #(.WORD_BITS(32), .RATE_BITS(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tick_en      (tick_en),
    .target_i     (target_i),
    .target_valid (target_valid),
    .step_i       (step_i),
    .exp_mode_i   (exp_mode_i),
    .phase_inc_o  (phase_inc_o),
    .gliding_o    (gliding_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tv;
    logic [31:0] tgt;
    logic [15:0] step;
    logic        tick;
    logic [31:0] e_phase;
    logic        e_gl;
    logic        e_done;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, sample 1 time unit later
  task automatic step_cycle(input logic tv, input logic [31:0] tgt,
                            input logic [15:0] stp, input logic tk);
    target_valid = tv;
    target_i     = tgt;
    step_i       = stp;
    tick_en      = tk;
    @(posedge clk);
    #1;
    target_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] exp_ph;
    int          done_cnt;
    int          ticks;

    vecs[0]  = '{1'b1, 32'h300, 16'h100, 1'b0, 32'h000, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,   16'h100, 1'b1, 32'h100, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,   16'h100, 1'b0, 32'h100, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,   16'h100, 1'b1, 32'h200, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,   16'h180, 1'b1, 32'h300, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,   16'h180, 1'b1, 32'h300, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h300, 16'h100, 1'b0, 32'h300, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,   16'h100, 1'b1, 32'h300, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h50,  16'h000, 1'b0, 32'h050, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 32'h10,  16'h030, 1'b1, 32'h050, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h0,   16'h030, 1'b1, 32'h020, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h0,   16'h030, 1'b1, 32'h010, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 32'h0,   16'h000, 1'b1, 32'h010, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 32'h0,   16'h030, 1'b0, 32'h010, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 32'h0,   16'h030, 1'b1, 32'h000, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 32'h0,   16'h030, 1'b1, 32'h000, 1'b0, 1'b0};

    n_rst = 1'b0; tick_en = 1'b0; target_i = '0; target_valid = 1'b0;
    step_i = '0; exp_mode_i = 1'b0;
    #12;
    check("reset_phase", phase_inc_o, 32'h0);
    check("reset_gliding", {31'b0, gliding_o}, 32'h0);
    check("reset_done", {31'b0, done_o}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      step_cycle(vecs[i].tv, vecs[i].tgt, vecs[i].step, vecs[i].tick);
      check($sformatf("vec%0d_phase", i), phase_inc_o, vecs[i].e_phase);
      check($sformatf("vec%0d_gliding", i), {31'b0, gliding_o}, {31'b0, vecs[i].e_gl});
      check($sformatf("vec%0d_done", i), {31'b0, done_o}, {31'b0, vecs[i].e_done});
    end

    // Ramp 0 -> 0x1000 by 0x100, tick every cycle
    n_rst = 1'b0; #1; n_rst = 1'b1;
    step_cycle(1'b1, 32'h1000, 16'h100, 1'b1);
    check("ramp_load_nostep", phase_inc_o, 32'h0);
    done_cnt = 0;
    exp_ph = 32'h0;
    for (int k = 1; k <= 16; k++) begin
      step_cycle(1'b0, 32'h0, 16'h100, 1'b1);
      exp_ph = exp_ph + 32'h100;
      check($sformatf("ramp_tick%0d", k), phase_inc_o, exp_ph);
      if (done_o) done_cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      step_cycle(1'b0, 32'h0, 16'h100, 1'b1);
      if (done_o) done_cnt++;
    end
    check("ramp_done_count", done_cnt, 32'd1);
    check("ramp_final", phase_inc_o, 32'h1000);

    // Single-tick clamp down to 0xF80
    step_cycle(1'b1, 32'h0F80, 16'h100, 1'b0);
    check("clamp_dn_gliding", {31'b0, gliding_o}, 32'h1);
    step_cycle(1'b0, 32'h0, 16'h100, 1'b1);
    check("clamp_dn_phase", phase_inc_o, 32'h0F80);
    check("clamp_dn_idle", {31'b0, gliding_o}, 32'h0);
    check("clamp_dn_done", {31'b0, done_o}, 32'h1);
    step_cycle(1'b0, 32'h0, 16'h100, 1'b1);
    check("clamp_dn_done_once", {31'b0, done_o}, 32'h0);

    // No wrap at the top of the word range
    step_cycle(1'b1, 32'hFFFF_FF00, 16'h0, 1'b0);
    check("top_jump", phase_inc_o, 32'hFFFF_FF00);
    step_cycle(1'b1, 32'hFFFF_FFFF, 16'hFFFF, 1'b0);
    step_cycle(1'b0, 32'h0, 16'hFFFF, 1'b1);
    check("top_nowrap", phase_inc_o, 32'hFFFF_FFFF);
    check("top_done", {31'b0, done_o}, 32'h1);

    // Retarget mid-glide coincident with a tick
    step_cycle(1'b1, 32'h0, 16'h0, 1'b0);
    check("zero_jump", phase_inc_o, 32'h0);
    step_cycle(1'b1, 32'h1000, 16'h100, 1'b0);
    for (int k = 0; k < 8; k++) step_cycle(1'b0, 32'h0, 16'h100, 1'b1);
    check("retgt_at_800", phase_inc_o, 32'h800);
    step_cycle(1'b1, 32'h400, 16'h100, 1'b1);
    check("retgt_nostep", phase_inc_o, 32'h800);
    check("retgt_gliding", {31'b0, gliding_o}, 32'h1);
    step_cycle(1'b0, 32'h0, 16'h100, 1'b1);
    check("retgt_falls", phase_inc_o, 32'h700);

    // Async reset between edges, mid-glide
    #3;
    n_rst = 1'b0;
    #1;
    check("arst_phase", phase_inc_o, 32'h0);
    check("arst_gliding", {31'b0, gliding_o}, 32'h0);
    check("arst_done", {31'b0, done_o}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step_cycle(1'b0, 32'h0, 16'h100, 1'b1);
      if (done_o || gliding_o || (phase_inc_o != 32'h0)) done_cnt++;
    end
    check("arst_quiet_after", done_cnt, 32'd0);

`ifdef GLIDE_EXP_EN
    // Exponential approach 0 -> 0x1_0000 with shift 4
    exp_mode_i = 1'b1;
    step_cycle(1'b1, 32'h1_0000, 16'd4, 1'b0);
    step_cycle(1'b0, 32'h0, 16'd4, 1'b1);
    check("exp_first", phase_inc_o, 32'h1000);
    step_cycle(1'b0, 32'h0, 16'd4, 1'b1);
    check("exp_second", phase_inc_o, 32'h1F00);
    prev = 32'hF00;
    done_cnt = 0;
    ticks = 0;
    exp_ph = phase_inc_o;
    while (!done_o && ticks < 2000) begin
      step_cycle(1'b0, 32'h0, 16'd4, 1'b1);
      if ((phase_inc_o - exp_ph) > prev) done_cnt++;
      prev = phase_inc_o - exp_ph;
      exp_ph = phase_inc_o;
      ticks++;
    end
    check("exp_shrinking", done_cnt, 32'd0);
    check("exp_terminated", {31'b0, done_o}, 32'h1);
    check("exp_final", phase_inc_o, 32'h1_0000);
    exp_mode_i = 1'b0;
`else
    prev = 32'h0;
    ticks = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/glide_slewer.md
GLIDE_SLEWER -- requirements
Module: glide_slewer

Interface
REQ-001 The block SHALL have parameter WORD_BITS, default 32, setting the phase-increment (tuning word) width.
REQ-002 The block SHALL have parameter RATE_BITS, default 16, setting the glide step width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port tick_en, input, 1 bit: sample-rate enable, the same strobe that drives the downstream accumulator enable.
REQ-006 The block SHALL have port target_i, input, WORD_BITS bits: requested tuning word.
REQ-007 The block SHALL have port target_valid, input, 1 bit: a one-cycle strobe that loads target_i.
REQ-008 The block SHALL have port step_i, input, RATE_BITS bits: linear glide step per tick, zero-extended to WORD_BITS.
REQ-009 The block SHALL have port exp_mode_i, input, 1 bit: selects exponential glide (see Configuration).
REQ-010 The block SHALL have port phase_inc_o, output, WORD_BITS bits: current tuning word; feeds the phase accumulator phase_i.
REQ-011 The block SHALL have port gliding_o, output, 1 bit: high while the FSM is in UP or DOWN.
REQ-012 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse when phase_inc_o reaches the target.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, UP, DOWN.
REQ-014 target_valid high at edge N SHALL latch target_i into the target register at edge N.
- The FSM SHALL enter UP if target > phase_inc_o, DOWN if target < phase_inc_o, IDLE if equal.
- The new state SHALL be visible from N+1.
REQ-015 If target_valid arrives with target equal to phase_inc_o, the block SHALL stay in IDLE and SHALL pulse done_o at N+1.
REQ-016 If target_valid arrives with step_i == 0 (and linear mode), the block SHALL load phase_inc_o = target at edge N, SHALL stay in IDLE, and SHALL pulse done_o at N+1.
REQ-017 In UP, on each tick_en cycle, the block SHALL update phase_inc_o <= min(phase_inc_o + step, target).
- The sum SHALL be computed at WORD_BITS+1 bits.
- The result SHALL never wrap past 2^WORD_BITS-1.
REQ-018 In DOWN, on each tick_en cycle, the block SHALL update phase_inc_o <= max(phase_inc_o - step, target).
- The difference SHALL be computed with borrow.
- The result SHALL never underflow below 0.
REQ-019 The cycle on which phase_inc_o becomes equal to target SHALL move the FSM to IDLE; done_o SHALL pulse on the following cycle only.
REQ-020 phase_inc_o SHALL hold its value in IDLE and on non-tick cycles.
REQ-021 If target_valid and tick_en are both high in the same cycle, the target load SHALL take priority and no step SHALL be applied that cycle.
REQ-022 A retarget mid-glide SHALL restart from the current phase_inc_o with direction re-evaluated; no jump or reset of phase_inc_o SHALL occur.
REQ-023 step_i SHALL be sampled on every tick, so a rate change takes effect on the next tick.
REQ-024 gliding_o SHALL be registered, i.e. derived from the state register.

Reset
REQ-025 When n_rst is low, the block SHALL asynchronously clear phase_inc_o, the target register, done_o and gliding_o to 0, and SHALL set the FSM to IDLE.
REQ-026 A reset asserted mid-glide SHALL abandon the glide; no done_o pulse SHALL follow the release of reset.
REQ-027 Reset release SHALL be synchronised by the instantiating design; the block SHALL assume no extra synchroniser internally.

Configuration
REQ-028 Macro GLIDE_EXP_EN: when defined and exp_mode_i = 1, the per-tick step SHALL be max(|target - phase_inc_o| >> step_i[4:0], 1).
- This gives a constant-time-ratio exponential approach that always terminates.
- Clamping rules REQ-017 and REQ-018 SHALL still apply.
REQ-029 Without GLIDE_EXP_EN, exp_mode_i SHALL be ignored, only linear stepping SHALL exist, and the subtract/shift logic SHALL not be synthesised.

Verification
REQ-030 Reset, then target 0x0000_1000 with step 0x100, tick_en every cycle: the output SHALL rise by 0x100 per tick, reach 0x1000 after 16 ticks, and pulse done_o once.
REQ-031 From 0x1000, target 0x0000_0F80 with step 0x100: a single tick SHALL clamp the output to 0x0F80, followed by IDLE and a done_o pulse.
REQ-032 From 0xFFFF_FF00, target 0xFFFF_FFFF with step 0xFFFF: the output SHALL become 0xFFFF_FFFF with no wrap.
REQ-033 Mid-glide UP at 0x800, retarget 0x400 in the same cycle as tick_en: there SHALL be no step that cycle, the FSM SHALL go to DOWN, and the output SHALL fall from 0x800.
REQ-034 Assert n_rst low mid-glide between clock edges: the outputs SHALL go to 0 immediately, with no done_o after release.
REQ-035 With GLIDE_EXP_EN defined: 0 to target 0x1_0000, shift 4: the first step SHALL be 0x1000, successive steps SHALL shrink, and the output SHALL terminate exactly at 0x1_0000 with a done_o pulse.
